// File: rtl/image_writer.sv
`default_nettype none
// ============================================================================
// Module   : image_writer
// Purpose  : AXI-Stream sink that writes 128-bit ciphertext blocks to
//            consecutive BRAM addresses starting at 0, and reports
//            completion plus stream-length / byte-enable errors.
// Ports    : clk, rst_n (async active-low)
//            start       - arm reception (ignored while receiving)
//            done        - high from end of stream until next accepted start
//            error[2:0]  - sticky {keep, overflow, short} flags
//            word_count  - beats written in current / last run
//            s_axis_*    - AXI-Stream slave (tready is registered)
//            bram_*      - BRAM write port (one-cycle write per beat)
// Revision : 1.0 - initial release
// ============================================================================
module image_writer #(
    parameter int IMAGE_DEPTH = 768,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  done,
    output logic [2:0]            error,
    output logic [ADDR_WIDTH:0]   word_count,
    input  logic [127:0]          s_axis_tdata,
    input  logic [15:0]           s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [127:0]          bram_din,
    output logic [15:0]           bram_we,
    output logic                  bram_en
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DRAIN   = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_last_ptr  = ADDR_WIDTH'(IMAGE_DEPTH - 1);
    localparam logic [15:0]           c_full_keep = 16'hFFFF;

    state_t                r_state,      w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr,        w_ptr_nxt;
    logic                  r_tready,     w_tready_nxt;
    logic                  r_done,       w_done_nxt;
    logic [2:0]            r_error,      w_error_nxt;
    logic [ADDR_WIDTH:0]   r_word_count, w_word_count_nxt;
    logic [ADDR_WIDTH-1:0] r_bram_addr,  w_bram_addr_nxt;
    logic [127:0]          r_bram_din,   w_bram_din_nxt;
    logic [15:0]           r_bram_we,    w_bram_we_nxt;
    logic                  r_bram_en,    w_bram_en_nxt;

    logic                  w_hs;

    // tready is a register, so the handshake never feeds back into it
    // combinationally within the same cycle.
    assign w_hs = s_axis_tvalid & r_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_tready     <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 3'b000;
            r_word_count <= '0;
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
            r_bram_we    <= '0;
            r_bram_en    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_tready     <= w_tready_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_word_count <= w_word_count_nxt;
            r_bram_addr  <= w_bram_addr_nxt;
            r_bram_din   <= w_bram_din_nxt;
            r_bram_we    <= w_bram_we_nxt;
            r_bram_en    <= w_bram_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_tready_nxt     = r_tready;
        w_done_nxt       = r_done;
        w_error_nxt      = r_error;
        w_word_count_nxt = r_word_count;
        w_bram_addr_nxt  = r_bram_addr;
        w_bram_din_nxt   = r_bram_din;
        // Write strobes are single-cycle: they fall unless a beat is written.
        w_bram_we_nxt    = '0;
        w_bram_en_nxt    = 1'b0;

        case (r_state)
            IDLE, DONE_ST: begin
                w_tready_nxt = 1'b0;
                if (start) begin
                    w_done_nxt       = 1'b0;
                    w_error_nxt      = 3'b000;
                    w_word_count_nxt = '0;
                    w_ptr_nxt        = '0;
                    w_tready_nxt     = 1'b1;
                    w_state_nxt      = RECV;
                end
            end

            RECV: begin
                if (w_hs) begin
                    w_bram_addr_nxt  = r_ptr;
                    w_bram_din_nxt   = s_axis_tdata;
                    w_bram_we_nxt    = s_axis_tkeep;
                    w_bram_en_nxt    = 1'b1;
                    w_ptr_nxt        = r_ptr + 1'b1;
                    w_word_count_nxt = r_word_count + 1'b1;
                    if (s_axis_tkeep != c_full_keep) begin
                        w_error_nxt[2] = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        if (r_ptr != c_last_ptr) begin
                            w_error_nxt[0] = 1'b1;
                        end
                        w_tready_nxt = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = DONE_ST;
                    end else if (r_ptr == c_last_ptr) begin
                        // Image full without tlast: swallow the rest of the
                        // stream so the upstream is not stalled forever.
                        w_error_nxt[1] = 1'b1;
                        w_state_nxt    = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (w_hs && s_axis_tlast) begin
                    w_tready_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = DONE_ST;
                end
            end

            default: begin
                w_state_nxt  = IDLE;
                w_tready_nxt = 1'b0;
            end
        endcase
    end

    assign s_axis_tready = r_tready;
    assign done          = r_done;
    assign error         = r_error;
    assign word_count    = r_word_count;
    assign bram_addr     = r_bram_addr;
    assign bram_din      = r_bram_din;
    assign bram_we       = r_bram_we;
    assign bram_en       = r_bram_en;

endmodule
`default_nettype wire
